hysteresis_ctrl: RTL and testbench



---
 rtl/ctrl_pkg.sv | 10 +
 rtl/sat_counter.sv | 16 +
 rtl/hysteresis_ctrl.sv | 68 ++++++
 tb/tb_hysteresis_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding for the hysteresis controller
package ctrl_pkg;
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {
    S_IDLE = 2'd0,
    S_COOL = 2'd1,
    S_HEAT = 2'd2,
    S_ILL  = 2'd3
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with load-to-one and parametrised reset value
module sat_counter #(
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= RST_VAL;
    else if (load) cnt <= CNT_W'(1);
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/hysteresis_ctrl.sv
// hysteresis_ctrl: thermostat FSM with hysteresis band and min-on/min-off anti-short-cycle timers
module hysteresis_ctrl
  import ctrl_pkg::*;
#(
  parameter int W           = 8,
  parameter int MIN_ON_CYC  = 4,
  parameter int MIN_OFF_CYC = 3,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] temp,
  input  logic [W-1:0] hi_th,
  input  logic [W-1:0] lo_th,
  input  logic [W-1:0] hyst,
  output logic         heat_on,
  output logic         cool_on,
  output logic [1:0]   state_o,
  output logic         lockout,
  output logic         cfg_err
);
  localparam logic [CNT_W-1:0] ON_MIN  = CNT_W'(MIN_ON_CYC);
  localparam logic [CNT_W-1:0] OFF_MIN = CNT_W'(MIN_OFF_CYC);
  state_t state, nxt;
  logic [CNT_W-1:0] on_cnt, off_cnt;
  logic [W:0] ce_raw, he_raw;
  logic [W-1:0] cool_exit, heat_exit;
  logic active, on_done, stop;
  assign ce_raw    = {1'b0, hi_th} - {1'b0, hyst};
  assign he_raw    = {1'b0, lo_th} + {1'b0, hyst};
  assign cool_exit = ce_raw[W] ? '0 : ce_raw[W-1:0];
  assign heat_exit = he_raw[W] ? '1 : he_raw[W-1:0];
  assign cfg_err   = lo_th >= hi_th;
  assign active    = state == S_COOL || state == S_HEAT;
  assign on_done   = on_cnt >= ON_MIN;
  assign stop      = !en || cfg_err;
  assign lockout   = state == S_IDLE && off_cnt < OFF_MIN;
  assign heat_on   = state == S_HEAT;
  assign cool_on   = state == S_COOL;
  assign state_o   = state;
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = (stop || lockout) ? S_IDLE : temp >= hi_th ? S_COOL : temp <= lo_th ? S_HEAT : S_IDLE;
      S_COOL:  nxt = (stop || (temp <= cool_exit && on_done)) ? S_IDLE : S_COOL;
      S_HEAT:  nxt = (stop || (temp >= heat_exit && on_done)) ? S_IDLE : S_HEAT;
      default: nxt = S_IDLE;
    endcase
  end
  sat_counter #(.CNT_W(CNT_W), .RST_VAL('0)) u_on (
    .clk  (clk),
    .rst  (rst),
    .load (state == S_IDLE && nxt != S_IDLE),
    .inc  (active),
    .cnt  (on_cnt)
  );
  sat_counter #(.CNT_W(CNT_W), .RST_VAL(OFF_MIN)) u_off (
    .clk  (clk),
    .rst  (rst),
    .load (active && nxt == S_IDLE),
    .inc  (state == S_IDLE),
    .cnt  (off_cnt)
  );
endmodule

// File: tb/tb_hysteresis_ctrl.sv
// tb_hysteresis_ctrl: directed self-checking bench for the thermostat controller
module tb_hysteresis_ctrl;
  logic clk = 0, rst = 1, en = 1;
  logic [7:0] temp = 80, hi_th = 90, lo_th = 70, hyst = 5;
  logic heat_on, cool_on, lockout, cfg_err;
  logic [1:0] state_o;
  int pass_cnt = 0, total = 0;
  hysteresis_ctrl #(.W(8), .MIN_ON_CYC(4), .MIN_OFF_CYC(3), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .temp    (temp),
    .hi_th   (hi_th),
    .lo_th   (lo_th),
    .hyst    (hyst),
    .heat_on (heat_on),
    .cool_on (cool_on),
    .state_o (state_o),
    .lockout (lockout),
    .cfg_err (cfg_err)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic chk_all(input string tag, input int st, input int lk);
    chk({tag, "_state"}, int'(state_o), st);
    chk({tag, "_heat"}, int'(heat_on), int'(st == 2));
    chk({tag, "_cool"}, int'(cool_on), int'(st == 1));
    chk({tag, "_lock"}, int'(lockout), lk);
  endtask
  initial begin
    tick();
    rst = 0;
    chk_all("reset", 0, 0);
    chk("reset_cfg", int'(cfg_err), 0);
    for (int t = 71; t <= 89; t++) begin
      temp = 8'(t);
      tick();
      chk("sweep_idle", int'(state_o), 0);
    end
    temp = 90;
    tick();
    chk_all("enter_cool", 1, 0);
    temp = 86;
    tick();
    chk("hold86_a", int'(state_o), 1);
    tick();
    chk("hold86_b", int'(state_o), 1);
    tick();
    chk("hold86_c", int'(state_o), 1);
    temp = 85;
    tick();
    chk_all("exit_cool", 0, 1);
    temp = 60;
    tick();
    chk_all("lock2", 0, 1);
    tick();
    chk_all("lock_end", 0, 0);
    tick();
    chk_all("enter_heat", 2, 0);
    en = 0;
    tick();
    chk_all("en_drop", 0, 1);
    en = 1;
    temp = 80;
    tick(2);
    chk("idle_mid", int'(state_o), 0);
    temp = 90;
    tick();
    chk("minon_1", int'(cool_on), 1);
    temp = 80;
    tick();
    chk("minon_2", int'(cool_on), 1);
    tick();
    chk("minon_3", int'(cool_on), 1);
    tick();
    chk("minon_4", int'(cool_on), 1);
    temp = 70;
    tick();
    chk_all("minon_off", 0, 1);
    tick();
    chk_all("lock_no_heat_a", 0, 1);
    tick();
    chk_all("lock_no_heat_b", 0, 0);
    tick();
    chk_all("heat_after_lock", 2, 0);
    hi_th = 70;
    lo_th = 90;
    #1;
    chk("cfg_err_set", int'(cfg_err), 1);
    tick();
    chk_all("cfg_err_drop", 0, 1);
    tick(2);
    temp = 0;
    tick();
    chk("cfg_t0", int'(state_o), 0);
    temp = 255;
    tick();
    chk("cfg_t255", int'(state_o), 0);
    hi_th = 90;
    lo_th = 70;
    temp = 95;
    tick();
    chk("pre_rst_cool", int'(state_o), 1);
    rst = 1;
    tick();
    chk_all("mid_rst", 0, 0);
    rst = 0;
    tick();
    chk("restart", int'(state_o), 1);
    temp = 80;
    tick(4);
    chk_all("restart_exit", 0, 1);
    tick(2);
    hi_th = 3;
    lo_th = 0;
    hyst = 10;
    temp = 3;
    tick();
    chk("clamp_enter", int'(state_o), 1);
    temp = 1;
    tick(4);
    chk("clamp_hold", int'(state_o), 1);
    temp = 0;
    tick();
    chk("clamp_exit", int'(state_o), 0);
    hi_th = 255;
    lo_th = 250;
    temp = 252;
    tick(2);
    temp = 250;
    tick();
    chk("sat_enter_heat", int'(state_o), 2);
    temp = 254;
    tick(4);
    chk("sat_hold_heat", int'(state_o), 2);
    temp = 255;
    tick();
    chk("sat_exit_heat", int'(state_o), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
